// File: rtl/decim_comb.sv
// Decimating comb section of a CIC decimator: keeps every R-th valid sample and
// passes it through N registered comb stages of differential delay M.
module decim_comb #(
  parameter int IW = 2,
  parameter int OW = 5,
  parameter int R  = 4,
  parameter int M  = 1,
  parameter int N  = 3
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [IW-1:0] i_data,
  input  logic          i_ready,
  output logic [OW-1:0] o_data,
  output logic          o_ready
);

  localparam int CW = (R > 1) ? $clog2(R) : 1;

  // Handshake: i_ready qualifies i_data for one cycle, there is no backpressure;
  // o_ready is a one-cycle strobe qualifying o_data, which holds between strobes.

  logic [CW-1:0] cnt;
  logic          accept;

  // stg[0] is the registered chain input; stg[k] is the output of comb stage k.
  logic [OW-1:0] stg [0:N];
  logic [N:0]    vld;
  logic [OW-1:0] dly [1:N][0:M-1];

  assign accept = i_ready && (cnt == CW'(R - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt <= '0;
      vld <= '0;
      for (int k = 0; k <= N; k++) stg[k] <= '0;
      for (int k = 1; k <= N; k++)
        for (int j = 0; j < M; j++) dly[k][j] <= '0;
    end else begin
      if (i_ready) cnt <= accept ? '0 : cnt + CW'(1);

      vld[0] <= accept;
      if (accept) stg[0] <= OW'($signed(i_data));

      // Each delay line advances only when its own stage input is valid, so
      // idle cycles between decimated samples never disturb the comb history.
      for (int k = 1; k <= N; k++) begin
        vld[k] <= vld[k-1];
        if (vld[k-1]) begin
          stg[k]    <= stg[k-1] - dly[k][M-1];
          dly[k][0] <= stg[k-1];
          for (int j = 1; j < M; j++) dly[k][j] <= dly[k][j-1];
        end
      end
    end
  end

  assign o_data  = stg[N];
  assign o_ready = vld[N];

endmodule
